// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
//
// Purpose:
//   Radix-2 shift-add multiplier and restoring divider that sits beside the EX
//   stage. An op goes IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE. HI/LO are
//   written at the end of FIX, or straight from PREP for a zero divisor. While
//   the unit is busy, any MFHI/MFLO, MTHI/MTLO or new op stalls the pipeline.
//
// Configuration:
//   MULDIV_EARLY_OUT_EN  when defined, multiplies leave RUN as soon as the
//                        remaining multiplier bits are all zero. Divides are
//                        unaffected.
//
// Ports:
//   clk      in   1      system clock
//   reset    in   1      synchronous, active-high
//   start    in   1      issue op this cycle
//   op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val   in   WIDTH  operand A / dividend
//   rt_val   in   WIDTH  operand B / divisor
//   rd_req   in   1      MFHI/MFLO waiting in ID
//   wr_hi    in   1      MTHI write request
//   wr_lo    in   1      MTLO write request
//   wr_data  in   WIDTH  MTHI/MTLO data
//   flush    in   1      cancel in-flight op
//   busy     out  1      state != IDLE
//   stall    out  1      busy & (rd_req | start | wr_hi | wr_lo)
//   done     out  1      one-cycle pulse after HI/LO were updated by an op
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register

module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;      // raw rs, kept for the zero-divisor HI result
  logic [WIDTH-1:0] b_q;      // raw rt
  logic [WIDTH-1:0] d_q;      // magnitude: multiplicand (|rs|) or divisor (|rt|)
  logic [WIDTH-1:0] acc_q;    // product high half / partial remainder
  logic [WIDTH-1:0] mplr_q;   // multiplier then product low half / dividend then quotient
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             sign_r;

  logic is_div;
  logic is_signed;
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Operand magnitudes for the signed ops; unsigned ops pass through.
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  assign a_abs = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // One iteration of each algorithm.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH-1:0] mul_mplr_n;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_n;
  logic [WIDTH-1:0] div_quot_n;

  always_comb begin
    // Keep the add carry: it becomes the top bit after the right shift.
    mul_sum    = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, d_q} : {(WIDTH+1){1'b0}});
    mul_acc_n  = mul_sum[WIDTH:1];
    mul_mplr_n = {mul_sum[0], mplr_q[WIDTH-1:1]};

    // Remainder is always < divisor, so the shifted value fits in WIDTH+1 bits
    // and the borrow out of the subtraction is the "remainder < divisor" flag.
    div_rem_sh = {acc_q, mplr_q[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, d_q};
    div_ge     = ~div_diff[WIDTH];
    div_rem_n  = div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0];
    div_quot_n = {mplr_q[WIDTH-2:0], div_ge};
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quot;
  logic [WIDTH-1:0]   fix_rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod     = {acc_q, mplr_q};
    fix_prod = (is_signed && sign_q) ? -prod : prod;
    fix_quot = (is_signed && sign_q) ? -mplr_q : mplr_q;
    fix_rem  = (is_signed && sign_r) ? -acc_q : acc_q;
    fix_hi   = is_div ? fix_rem  : fix_prod[2*WIDTH-1:WIDTH];
    fix_lo   = is_div ? fix_quot : fix_prod[WIDTH-1:0];
  end

  logic early_exit;
`ifdef MULDIV_EARLY_OUT_EN
  // After this cycle's shift, the cnt_q not-yet-consumed multiplier bits sit
  // in mul_mplr_n[cnt_q-1:0]. If they are all zero the remaining iterations
  // would only shift, so do all of those shifts at once.
  logic [WIDTH-1:0]   rem_mask;
  logic [2*WIDTH-1:0] early_prod;
  assign rem_mask   = ~({WIDTH{1'b1}} << cnt_q);
  assign early_exit = ~is_div && ((mul_mplr_n & rem_mask) == {WIDTH{1'b0}});
  assign early_prod = {mul_acc_n, mul_mplr_n} >> cnt_q;
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= 2'b00;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      acc_q  <= '0;
      mplr_q <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      // MTHI/MTLO land only while idle; during busy they are held off by stall.
      if (state == ST_IDLE) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end

      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              op_q  <= op;
              a_q   <= rs_val;
              b_q   <= rt_val;
              state <= ST_PREP;
            end
          end

          ST_PREP: begin
            sign_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
            sign_r <= a_q[WIDTH-1];
            acc_q  <= '0;
            cnt_q  <= CNT_W'(WIDTH - 1);
            if (is_div) begin
              d_q    <= b_abs;
              mplr_q <= a_abs;
            end else begin
              d_q    <= a_abs;
              mplr_q <= b_abs;
            end
            if (is_div && (b_q == '0)) begin
              hi    <= a_q;
              lo    <= '1;
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end

          ST_RUN: begin
            if (is_div) begin
              acc_q  <= div_rem_n;
              mplr_q <= div_quot_n;
            end else begin
`ifdef MULDIV_EARLY_OUT_EN
              if (early_exit) begin
                {acc_q, mplr_q} <= early_prod;
              end else begin
                {acc_q, mplr_q} <= {mul_acc_n, mul_mplr_n};
              end
`else
              {acc_q, mplr_q} <= {mul_acc_n, mul_mplr_n};
`endif
            end
            if ((cnt_q == '0) || early_exit) begin
              state <= ST_FIX;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end

          ST_FIX: begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            state <= ST_DONE;
          end

          ST_DONE: state <= ST_IDLE;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign stall = busy & (rd_req | start | wr_hi | wr_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_req;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .rd_req(rd_req),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t        vecs [14];
  logic [63:0] sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edges from the start edge until done is first seen; 0 marks a zero divisor.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[1] && b == 32'd0) return 0;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      logic [31:0] m;
      int c;
      m = (!o[0] && b[31]) ? -b : b;
      c = 1;
      for (int i = 0; i < 32; i++) if (m[i]) c = i + 1;
      return c + 2;
    end
`endif
    return a == a ? WIDTH + 2 : 0;
  endfunction

  // mode 0 plain, 1 rd_req held through op, 2 MTLO during DONE then in IDLE,
  // 3 MTHI in the same cycle as start
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input int mode);
    int k;
    int lat;
    logic [63:0] exp;
    lat = exp_lat(o, a, b);
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    if (mode == 3) begin wr_hi = 1'b1; wr_data = 32'h77; end
    sb_q.push_back({e_hi, e_lo});
    @(posedge clk); #1;
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    if (mode == 3) begin
      wr_hi = 1'b0;
      check("mthi_with_start", hi, 32'h77);
      check("busy_after_start", busy, 1);
    end
    if (mode == 1) rd_req = 1'b1;
    k = 0;
    while (k < 200 && !done) begin
      if (mode == 1) check("stall_rd_req", stall, 1);
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      sb_q.delete();
      rd_req = 1'b0;
      return;
    end
    if (lat == 0) check("lat_div0", k <= 2, 1);
    else          check("latency", k, lat);
    exp = sb_q.pop_front();
    check("hi", hi, exp[63:32]);
    check("lo", lo, exp[31:0]);
    check("busy_in_done", busy, 1);
    if (mode == 1) check("stall_in_done", stall, 1);
    if (mode == 2) begin wr_lo = 1'b1; wr_data = 32'h1234; end
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    if (mode == 1) begin check("stall_idle", stall, 0); rd_req = 1'b0; end
    if (mode == 2) begin
      check("mtlo_busy_ignored", lo, exp[31:0]);
      @(posedge clk); #1;
      check("mtlo_idle", lo, 32'h1234);
      wr_lo = 1'b0;
    end
  endtask

  initial begin
    int seen;
    int skip;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    rd_req = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; flush = 1'b0;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b01, 32'd9,        32'd1,        32'd0,        32'd9};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[11] = '{2'b01, 32'h12345678, 32'd0,        32'd0,        32'd0};
    vecs[12] = '{2'b00, 32'd5,        32'd6,        32'd0,        32'd30};
    vecs[13] = '{2'b11, 32'd5,        32'd7,        32'd5,        32'd0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_stall", stall, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e_hi, vecs[i].e_lo,
             (i == 2) ? 1 : (i == 4) ? 2 : 0);

    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 3);

    // HI/LO = 0xAA/0xBB, then flush a MULT 5*6 mid-RUN.
    @(negedge clk); wr_hi = 1'b1; wr_data = 32'hAA;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'hBB;
    @(negedge clk); wr_lo = 1'b0;
    op = 2'b00; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
`ifdef MULDIV_EARLY_OUT_EN
    skip = 1;
`else
    skip = 9;
`endif
    repeat (skip) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_run_busy", busy, 0);
    check("flush_run_hi", hi, 32'hAA);
    check("flush_run_lo", lo, 32'hBB);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1; end
    check("flush_no_done", seen, 0);

    // Flush landing in the FIX cycle must leave HI/LO alone.
    @(negedge clk);
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (WIDTH + 1) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_fix_busy", busy, 0);
    check("flush_fix_hi", hi, 32'hAA);
    check("flush_fix_lo", lo, 32'hBB);

    // flush and start together in IDLE: flush wins.
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);

    // Reset in the middle of a DIV.
    @(negedge clk);
    op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    check("rst_mid_done", done, 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
